// File: rtl/fmul32_operand_unpack.sv
// Operand unpacker for the FMUL32 datapath.
// Two-stage valid/ready pipeline: stage 1 captures the raw fields and the
// per-operand class flags; stage 2 restores the hidden bits, forms the biased
// exponent sum and resolves the special-case condition code.
module fmul32_operand_unpack #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23,
  parameter int BIAS   = 127
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [EXP_W+FRAC_W:0]   op_a,
  input  logic [EXP_W+FRAC_W:0]   op_b,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    sign_res,
  output logic [FRAC_W:0]         mant_a,
  output logic [FRAC_W:0]         mant_b,
  output logic [EXP_W+1:0]        exp_sum,
  output logic [1:0]              denorm_ab,
  output logic [1:0]              exp_condition
);

  localparam int OP_W = 1 + EXP_W + FRAC_W;
  localparam logic [EXP_W+1:0] BIAS_W = (EXP_W+2)'(BIAS);
  localparam logic [EXP_W-1:0] EXP_ONE = {{(EXP_W-1){1'b0}}, 1'b1};

  // Index 1 is operand A, index 0 is operand B, matching denorm_ab.
  logic [1:0][OP_W-1:0]   op_in;
  logic [1:0][EXP_W-1:0]  exp_in;
  logic [1:0][FRAC_W-1:0] frac_in;
  logic [1:0]             zero_in, denorm_in, inf_in, nan_in;

  // Stage 1 registers
  logic                   s1_valid_reg;
  logic                   s1_sign_reg;
  logic [1:0][EXP_W-1:0]  s1_exp_reg;
  logic [1:0][FRAC_W-1:0] s1_frac_reg;
  logic [1:0]             s1_zero_reg, s1_denorm_reg, s1_inf_reg, s1_nan_reg;

  // Stage 2 (output) registers
  logic                   out_valid_reg;
  logic                   sign_res_reg;
  logic [FRAC_W:0]        mant_a_reg, mant_b_reg;
  logic [EXP_W+1:0]       exp_sum_reg;
  logic [1:0]             denorm_ab_reg;
  logic [1:0]             exp_condition_reg;

  // Stage 2 combinational results
  logic [1:0][FRAC_W:0]   mant_next;
  logic [1:0][EXP_W-1:0]  eff_exp;
  logic [EXP_W+1:0]       exp_sum_next;
  logic [1:0]             exp_condition_next;

  // Handshake: a stage may load when it is empty or its content is leaving.
  logic out_free;
  logic s1_free;

  assign out_free = !out_valid_reg || out_ready;
  assign s1_free  = !s1_valid_reg || out_free;
  assign in_ready = s1_free;

  assign op_in[1] = op_a;
  assign op_in[0] = op_b;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_operand
      // Field split and IEEE class decode of the incoming operand.
      assign exp_in[gi]    = op_in[gi][OP_W-2 -: EXP_W];
      assign frac_in[gi]   = op_in[gi][FRAC_W-1:0];
      assign zero_in[gi]   = (exp_in[gi] == '0) && (frac_in[gi] == '0);
      assign denorm_in[gi] = (exp_in[gi] == '0) && (frac_in[gi] != '0);
      assign inf_in[gi]    = (&exp_in[gi]) && (frac_in[gi] == '0);
      assign nan_in[gi]    = (&exp_in[gi]) && (frac_in[gi] != '0);

      // Denormals have no hidden bit but share the exponent of 2^(1-bias).
      assign mant_next[gi] = {(s1_exp_reg[gi] != '0), s1_frac_reg[gi]};
      assign eff_exp[gi]   = (s1_exp_reg[gi] == '0) ? EXP_ONE : s1_exp_reg[gi];
    end
  endgenerate

  // Unsaturated signed exponent sum; range problems are handled downstream.
  assign exp_sum_next = {2'b00, eff_exp[1]} + {2'b00, eff_exp[0]} - BIAS_W;

  // Special-case resolution, NaN > infinity > zero > normal; inf*0 is NaN.
  always_comb begin
    exp_condition_next = 2'b00;
    if ((|s1_nan_reg) || ((|s1_inf_reg) && (|s1_zero_reg))) begin
      exp_condition_next = 2'b11;
    end else if (|s1_inf_reg) begin
      exp_condition_next = 2'b10;
    end else if (|s1_zero_reg) begin
      exp_condition_next = 2'b01;
    end
  end

  // Stage 1: capture raw fields and class flags when an operand pair is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_reg  <= 1'b0;
      s1_sign_reg   <= 1'b0;
      s1_exp_reg    <= '0;
      s1_frac_reg   <= '0;
      s1_zero_reg   <= '0;
      s1_denorm_reg <= '0;
      s1_inf_reg    <= '0;
      s1_nan_reg    <= '0;
    end else begin
      if (s1_free) begin
        s1_valid_reg <= in_valid;
      end
      if (in_valid && s1_free) begin
        s1_sign_reg   <= op_a[OP_W-1] ^ op_b[OP_W-1];
        s1_exp_reg    <= exp_in;
        s1_frac_reg   <= frac_in;
        s1_zero_reg   <= zero_in;
        s1_denorm_reg <= denorm_in;
        s1_inf_reg    <= inf_in;
        s1_nan_reg    <= nan_in;
      end
    end
  end

  // Stage 2: load unpacked results on advance; hold them while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg     <= 1'b0;
      sign_res_reg      <= 1'b0;
      mant_a_reg        <= '0;
      mant_b_reg        <= '0;
      exp_sum_reg       <= '0;
      denorm_ab_reg     <= '0;
      exp_condition_reg <= '0;
    end else begin
      if (out_free) begin
        out_valid_reg <= s1_valid_reg;
      end
      if (s1_valid_reg && out_free) begin
        sign_res_reg      <= s1_sign_reg;
        mant_a_reg        <= mant_next[1];
        mant_b_reg        <= mant_next[0];
        exp_sum_reg       <= exp_sum_next;
        denorm_ab_reg     <= s1_denorm_reg;
        exp_condition_reg <= exp_condition_next;
      end
    end
  end

  assign out_valid     = out_valid_reg;
  assign sign_res      = sign_res_reg;
  assign mant_a        = mant_a_reg;
  assign mant_b        = mant_b_reg;
  assign exp_sum       = exp_sum_reg;
  assign denorm_ab     = denorm_ab_reg;
  assign exp_condition = exp_condition_reg;

endmodule

// File: tb/tb_fmul32_operand_unpack.sv
// Bench for fmul32_operand_unpack: directed vector table, backpressure and
// reset sequences, then randomized traffic scored against a reference model.
module tb_fmul32_operand_unpack;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] op_a, op_b;
  logic        out_valid;
  logic        out_ready;
  logic        sign_res;
  logic [23:0] mant_a, mant_b;
  logic [9:0]  exp_sum;
  logic [1:0]  denorm_ab;
  logic [1:0]  exp_condition;

  int tests = 0;
  int fails = 0;

  fmul32_operand_unpack #(.EXP_W(8), .FRAC_W(23), .BIAS(127)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .sign_res(sign_res), .mant_a(mant_a), .mant_b(mant_b),
    .exp_sum(exp_sum), .denorm_ab(denorm_ab), .exp_condition(exp_condition)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sign;
    logic [23:0] ma;
    logic [23:0] mb;
    logic [9:0]  esum;
    logic [1:0]  den;
    logic [1:0]  cond;
  } vec_t;

  vec_t vecs[11];
  logic [62:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  function automatic logic [62:0] dut_pack();
    return {sign_res, mant_a, mant_b, exp_sum, denorm_ab, exp_condition};
  endfunction

  function automatic logic [62:0] vec_pack(input vec_t v);
    return {v.sign, v.ma, v.mb, v.esum, v.den, v.cond};
  endfunction

  // Reference model: works directly from IEEE-754 meaning with integer math.
  function automatic logic [62:0] model(input logic [31:0] a, input logic [31:0] b);
    int ea, eb, fa, fb, sum;
    bit a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic [1:0] cond;
    logic [9:0] es;
    logic [23:0] ma, mb;
    ea = int'(a[30:23]); eb = int'(b[30:23]);
    fa = int'(a[22:0]);  fb = int'(b[22:0]);
    a_nan = (ea == 255) && (fa != 0);  b_nan = (eb == 255) && (fb != 0);
    a_inf = (ea == 255) && (fa == 0);  b_inf = (eb == 255) && (fb == 0);
    a_zero = (ea == 0) && (fa == 0);   b_zero = (eb == 0) && (fb == 0);
    sum = ((ea == 0) ? 1 : ea) + ((eb == 0) ? 1 : eb) - 127;
    es = 10'(sum);
    ma = 24'(fa + ((ea != 0) ? (1 << 23) : 0));
    mb = 24'(fb + ((eb != 0) ? (1 << 23) : 0));
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) cond = 2'b11;
    else if (a_inf || b_inf) cond = 2'b10;
    else if (a_zero || b_zero) cond = 2'b01;
    else cond = 2'b00;
    return {a[31] ^ b[31], ma, mb, es,
            {(ea == 0) && (fa != 0), (eb == 0) && (fb != 0)}, cond};
  endfunction

  function automatic logic [31:0] rand_op();
    logic [7:0]  e;
    logic [22:0] f;
    case ($urandom_range(0, 4))
      0:       e = 8'h00;
      1:       e = 8'hFF;
      default: e = 8'($urandom_range(0, 255));
    endcase
    f = ($urandom_range(0, 2) == 0) ? 23'h0 : 23'($urandom);
    return {1'($urandom), e, f};
  endfunction

  // Scoreboard and stall-stability monitor, sampled on the falling edge.
  logic        stalled = 1'b0;
  logic [62:0] held;
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      stalled = 1'b0;
    end else begin
      if (stalled) check("stall_hold", {1'b0, out_valid, dut_pack()}, {1'b0, 1'b1, held});
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("unexpected_output", 64'(out_valid), 64'(0));
        else check("stream_data", 64'(dut_pack()), 64'(exp_q.pop_front()));
      end
      if (in_valid && in_ready) exp_q.push_back(model(op_a, op_b));
      stalled = out_valid && !out_ready;
      held = dut_pack();
    end
  end

  // Present one operand pair, hold until accepted (bounded), release.
  task automatic send(input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    in_valid = 1'b1; op_a = a; op_b = b;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("send_timeout", 64'(in_ready), 64'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Single isolated vector with exact latency check; pipeline must be idle.
  task automatic apply_vec(input vec_t v, input int idx);
    in_valid = 1'b1; op_a = v.a; op_b = v.b;
    @(negedge clk);
    check($sformatf("vec%0d_ready", idx), 64'(in_ready), 64'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check($sformatf("vec%0d_early", idx), 64'(out_valid), 64'(0));
    @(negedge clk);
    check($sformatf("vec%0d", idx), {out_valid, dut_pack()}, {1'b1, vec_pack(v)});
    @(posedge clk); #1;
  endtask

  bit drv_done;
  logic [31:0] p[3];

  initial begin
    vecs[0]  = '{32'h3FC00000, 32'h40000000, 1'b0, 24'hC00000, 24'h800000, 10'd128, 2'b00, 2'b00};
    vecs[1]  = '{32'h00000001, 32'hBF800000, 1'b1, 24'h000001, 24'h800000, 10'd1,   2'b10, 2'b00};
    vecs[2]  = '{32'h00000000, 32'h7F800000, 1'b0, 24'h000000, 24'h800000, 10'd129, 2'b00, 2'b11};
    vecs[3]  = '{32'h7F800000, 32'h3F800000, 1'b0, 24'h800000, 24'h800000, 10'd255, 2'b00, 2'b10};
    vecs[4]  = '{32'h80000000, 32'h3F800000, 1'b1, 24'h000000, 24'h800000, 10'd1,   2'b00, 2'b01};
    vecs[5]  = '{32'h7FC00000, 32'h00000000, 1'b0, 24'hC00000, 24'h000000, 10'd129, 2'b00, 2'b11};
    vecs[6]  = '{32'h7F000000, 32'h7F000000, 1'b0, 24'h800000, 24'h800000, 10'd381, 2'b00, 2'b00};
    vecs[7]  = '{32'h00800000, 32'h00800000, 1'b0, 24'h800000, 24'h800000, 10'h383, 2'b00, 2'b00};
    vecs[8]  = '{32'h3F800000, 32'h80400000, 1'b1, 24'h800000, 24'h400000, 10'd1,   2'b01, 2'b00};
    vecs[9]  = '{32'h7F800000, 32'hFF800000, 1'b1, 24'h800000, 24'h800000, 10'd383, 2'b00, 2'b10};
    vecs[10] = '{32'h3F800000, 32'h7F800001, 1'b0, 24'h800000, 24'h800001, 10'd255, 2'b00, 2'b11};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; op_a = '0; op_b = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_outputs", {out_valid, dut_pack()}, 64'(0));
    check("reset_in_ready", 64'(in_ready), 64'(1));
    @(posedge clk); #1;

    // Directed table
    for (int i = 0; i < 11; i++) apply_vec(vecs[i], i);

    // Backpressure: capacity two, frozen output, ordered drain
    for (int i = 0; i < 3; i++) p[i] = rand_op();
    out_ready = 1'b0;
    in_valid = 1'b1; op_a = p[0]; op_b = p[0] ^ 32'h80000000;
    @(negedge clk); check("bp_ready1", 64'(in_ready), 64'(1));
    @(posedge clk); #1;
    op_a = p[1]; op_b = vecs[0].a;
    @(negedge clk); check("bp_ready2", 64'(in_ready), 64'(1));
    @(posedge clk); #1;
    op_a = p[2]; op_b = vecs[1].b;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp_full_ready", 64'(in_ready), 64'(0));
      check("bp_frozen", {out_valid, dut_pack()}, {1'b1, model(p[0], p[0] ^ 32'h80000000)});
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp_drain_valid", 64'(out_valid), 64'(1));
      if (k == 0) check("bp_ready_release", 64'(in_ready), 64'(1));
      @(posedge clk); #1;
      if (k == 0) in_valid = 1'b0;
    end
    @(negedge clk);
    check("bp_drain_done", {out_valid, 32'(exp_q.size())}, 64'(0));
    @(posedge clk); #1;

    // Reset with two operands in flight
    send(vecs[2].a, vecs[2].b);
    send(vecs[3].a, vecs[3].b);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_flush_outputs", {out_valid, dut_pack()}, 64'(0));
    check("rst_flush_in_ready", 64'(in_ready), 64'(1));
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("rst_no_ghost", 64'(out_valid), 64'(0));
    end
    @(posedge clk); #1;
    apply_vec(vecs[0], 0);

    // Randomized traffic with random backpressure
    drv_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          send(rand_op(), rand_op());
          repeat ($urandom_range(0, 3) == 0 ? 1 : 0) begin
            @(posedge clk); #1;
          end
        end
        drv_done = 1'b1;
      end
      begin
        while (!drv_done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    begin
      int n = 0;
      while (exp_q.size() != 0 && n < 200) begin
        @(negedge clk);
        n++;
      end
    end
    @(negedge clk);
    check("final_drain", {out_valid, 32'(exp_q.size())}, 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
